instruction_fetch: RTL and testbench



---
 rtl/instruction_fetch_if.sv | 28 ++
 rtl/instruction_fetch.sv | 126 ++++++++++++
 tb/tb_instruction_fetch.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bundle: instruction-memory request/response, redirect from execute, decode handshake.
// master = fetch stage, slave = surrounding memory/execute/decode environment.
interface instruction_fetch_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        fetch_fault;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, fetch_fault,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
        input  instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, fetch_fault,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
        output instr_ready
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues in-order imem requests and buffers responses for decode.
// Define FETCH_ALIGN_CHECK_EN to halt with fetch_fault on a misaligned redirect target.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    instruction_fetch_if.master bus
);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {StRun, StHalt} state_e;

    state_e        r_state, w_state_d;
    logic [31:0]   r_fetch_pc;
    logic [CW-1:0] r_inflight, r_drop, r_count;
    logic [CW-1:0] w_inflight_d, w_drop_d;
    logic [31:0]   r_tag  [FIFO_DEPTH];
    logic [31:0]   r_data [FIFO_DEPTH];
    logic [31:0]   r_pc   [FIFO_DEPTH];
    logic [PW-1:0] r_tag_wp, r_tag_rp, r_wp, r_rp;

    logic          w_redirect, w_misaligned, w_accept, w_rsp, w_push, w_pop, w_req;
    logic [31:0]   w_redirect_pc;
    logic [CW:0]   w_credit;

    assign w_redirect = bus.redirect_valid;

`ifdef FETCH_ALIGN_CHECK_EN
    assign w_misaligned     = bus.redirect_pc[1:0] != 2'b00;
    assign w_redirect_pc    = bus.redirect_pc;
    assign bus.fetch_fault  = (r_state == StHalt);
`else
    assign w_misaligned     = 1'b0;
    assign w_redirect_pc    = {bus.redirect_pc[31:2], bus.redirect_pc[1:0] & 2'b00};
    assign bus.fetch_fault  = 1'b0;
`endif

    assign w_rsp    = bus.imem_rsp_valid;
    assign w_pop    = (r_count != '0) && bus.instr_ready;
    assign w_push   = w_rsp && (r_drop == '0) && !w_redirect;

    // A pop this cycle frees a slot, so one instruction per cycle can be sustained.
    assign w_credit = {1'b0, r_inflight} + {1'b0, r_count} - {{CW{1'b0}}, w_pop};
    assign w_req    = !i_rst && (r_state == StRun) && !w_redirect && (r_drop == '0) &&
                      (w_credit < (CW + 1)'(FIFO_DEPTH));
    assign w_accept = w_req && bus.imem_req_ready;

    assign bus.imem_req_valid = w_req;
    assign bus.imem_req_addr  = r_fetch_pc;
    assign bus.instr_valid    = (r_count != '0);
    assign bus.instr          = r_data[r_rp];
    assign bus.instr_pc       = r_pc[r_rp];

    always_comb begin
        w_state_d = r_state;
        if (w_redirect) begin
            w_state_d = w_misaligned ? StHalt : StRun;
        end
    end

    // Everything still outstanding after a redirect is stale and must be discarded.
    always_comb begin
        w_inflight_d = r_inflight + CW'(w_accept) - CW'(w_rsp);
        w_drop_d     = r_drop;
        if (w_redirect) begin
            w_drop_d = w_inflight_d;
        end else if (w_rsp && (r_drop != '0)) begin
            w_drop_d = r_drop - CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StRun;
            r_fetch_pc <= RESET_PC;
            r_inflight <= '0;
            r_drop     <= '0;
            r_count    <= '0;
            r_tag_wp   <= '0;
            r_tag_rp   <= '0;
            r_wp       <= '0;
            r_rp       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
                r_pc[i]   <= '0;
            end
        end else begin
            r_state    <= w_state_d;
            r_inflight <= w_inflight_d;
            r_drop     <= w_drop_d;
            if (w_redirect) begin
                r_fetch_pc <= w_redirect_pc;
            end else if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_redirect) begin
                r_tag_wp <= '0;
                r_tag_rp <= '0;
                r_wp     <= '0;
                r_rp     <= '0;
                r_count  <= '0;
            end else begin
                if (w_accept) begin
                    r_tag[r_tag_wp] <= r_fetch_pc;
                    r_tag_wp        <= r_tag_wp + 1'b1;
                end
                if (w_rsp && (r_drop == '0)) begin
                    r_tag_rp <= r_tag_rp + 1'b1;
                end
                if (w_push) begin
                    r_data[r_wp] <= bus.imem_rsp_data;
                    r_pc[r_wp]   <= r_tag[r_tag_rp];
                    r_wp         <= r_wp + 1'b1;
                end
                if (w_pop) begin
                    r_rp <= r_rp + 1'b1;
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: in-order memory model with variable latency, epoch-based
// reference model of the delivered instruction stream, plus directed literal expectations.
module tb_instruction_fetch;
    localparam int unsigned DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] KEY    = 32'hA5A5_0000;

    typedef struct packed {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } req_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instruction_fetch_if bus ();

    instruction_fetch #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Stimulus controls
    logic        ready_r  = 1'b1;
    logic        redir_v  = 1'b0;
    logic [31:0] redir_pc = 32'h0;
    int          lat      = 1;

    // Memory and reference model
    req_t        mq[$];
    int          epoch     = 0;
    int          m_buf     = 0;
    logic        m_fault   = 1'b0;
    logic [31:0] m_fetch   = RST_PC;
    logic [31:0] m_deliver = RST_PC;

    // Event trackers relative to the most recent redirect (or reset)
    int          redir_cyc     = -1;
    int          pr_acc        = -1;
    int          pr_val        = -1;
    logic        pr_seen       = 1'b0;
    logic [31:0] pr_pc         = 32'hDEAD_BEEF;
    logic        rsp_in_redir  = 1'b0;
    logic        pop_in_redir  = 1'b0;
    int          n_pop         = 0;
    int          n_acc         = 0;
    logic [31:0] last_pop_pc   = 32'hDEAD_BEEF;
    logic [31:0] last_acc_addr = 32'hDEAD_BEEF;
    logic [31:0] wrap_next     = 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive inputs after the falling edge, sample/check, then cross the rising edge.
    task automatic step();
        logic        rsp, acc, pop;
        int          stale;
        int          busy;
        req_t        h;
        logic [31:0] tgt;
        bus.instr_ready    = ready_r;
        bus.redirect_valid = redir_v;
        bus.redirect_pc    = redir_pc;
        bus.imem_req_ready = 1'b1;
        rsp = (mq.size() > 0) && (mq[0].due <= cyc);
        bus.imem_rsp_valid = rsp;
        bus.imem_rsp_data  = rsp ? (mq[0].addr ^ KEY) : 32'hDEAD_BEEF;
        #1;
        acc = bus.imem_req_valid && bus.imem_req_ready;
        pop = bus.instr_valid && bus.instr_ready;

        chk("instr_valid", 32'(bus.instr_valid), (m_buf > 0) ? 32'd1 : 32'd0);
        chk("fetch_fault", 32'(bus.fetch_fault), 32'(m_fault));
        if (redir_v) chk("req_in_redirect", 32'(bus.imem_req_valid), 32'd0);
        if (m_fault) chk("req_while_fault", 32'(bus.imem_req_valid), 32'd0);

        stale = 0;
        foreach (mq[i]) if (mq[i].epoch != epoch) stale++;
        if (acc) begin
            busy = mq.size() + m_buf - (pop ? 1 : 0);
            chk("req_addr", bus.imem_req_addr, m_fetch);
            chk("req_with_stale", 32'(stale), 32'd0);
            chk("req_over_credit", (busy < DEPTH) ? 32'd1 : 32'd0, 32'd1);
        end
        if (pop) begin
            chk("instr_pc", bus.instr_pc, m_deliver);
            chk("instr", bus.instr, m_deliver ^ KEY);
        end

        if (cyc > redir_cyc) begin
            if (acc && pr_acc < 0) pr_acc = cyc;
            if (bus.instr_valid && pr_val < 0) pr_val = cyc;
            if (pop && !pr_seen) begin
                pr_pc   = bus.instr_pc;
                pr_seen = 1'b1;
            end
        end

        if (rsp) begin
            h = mq.pop_front();
            if (h.epoch == epoch && !redir_v) m_buf++;
        end
        if (acc) begin
            mq.push_back('{addr: bus.imem_req_addr, due: cyc + lat, epoch: epoch});
            if (last_acc_addr == 32'hFFFF_FFFC) wrap_next = bus.imem_req_addr;
            last_acc_addr = bus.imem_req_addr;
            m_fetch       = m_fetch + 32'd4;
            n_acc++;
        end
        if (pop) begin
            last_pop_pc = bus.instr_pc;
            m_buf--;
            m_deliver = m_deliver + 32'd4;
            n_pop++;
        end

        if (redir_v) begin
            rsp_in_redir = rsp;
            pop_in_redir = pop;
            epoch++;
            m_buf = 0;
`ifdef FETCH_ALIGN_CHECK_EN
            m_fault = (redir_pc[1:0] != 2'b00);
            tgt     = redir_pc;
`else
            tgt     = {redir_pc[31:2], 2'b00};
`endif
            m_fetch   = tgt;
            m_deliver = tgt;
            redir_cyc = cyc;
            pr_acc    = -1;
            pr_val    = -1;
            pr_seen   = 1'b0;
            pr_pc     = 32'hDEAD_BEEF;
        end

        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic redirect(input logic [31:0] pc);
        redir_v  = 1'b1;
        redir_pc = pc;
        step();
        redir_v  = 1'b0;
    endtask

    initial begin
        int          p0;
        int          a0;
        logic [15:0] pat;
        rst                = 1'b1;
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_req_addr", bus.imem_req_addr, RST_PC);
        chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_instr", bus.instr, 32'h0);
        chk("rst_instr_pc", bus.instr_pc, 32'h0);
        chk("rst_fetch_fault", 32'(bus.fetch_fault), 32'd0);
        rst = 1'b0;
        cyc = 0;

        // Streaming with 1-cycle memory
        run(8);
        chk("first_req_cycle", 32'(pr_acc), 32'd0);
        chk("first_valid_cycle", 32'(pr_val), 32'd2);
        chk("first_pc", pr_pc, 32'h0);
        chk("sustained_pops", 32'(n_pop), 32'd6);

        // Decode stall: buffer fills, requests stop, nothing lost on release
        ready_r = 1'b0;
        p0 = n_pop;
        run(10);
        chk("stall_pops", 32'(n_pop - p0), 32'd0);
        chk("stall_req_low", 32'(bus.imem_req_valid), 32'd0);
        chk("stall_valid", 32'(bus.instr_valid), 32'd1);
        chk("stall_buffered", 32'(m_buf), 32'(DEPTH));
        ready_r = 1'b1;
        run(1);
        chk("release_pc", last_pop_pc, 32'h18);
        run(6);

        // Redirect latency in steady state
        redirect(32'h40);
        run(6);
        chk("redir_req_latency", 32'(pr_acc - redir_cyc), 32'd1);
        chk("redir_valid_latency", 32'(pr_val - redir_cyc), 32'd3);
        chk("redir_first_pc", pr_pc, 32'h40);

        // Irregular decode backpressure
        pat = 16'b1011_0011_1000_1101;
        for (int i = 0; i < 16; i++) begin
            ready_r = pat[i];
            step();
        end
        ready_r = 1'b1;
        run(4);

        // 3-cycle memory, redirect with two requests in flight
        lat = 3;
        for (int k = 0; k < 20 && mq.size() != 2; k++) step();
        chk("two_inflight", 32'(mq.size()), 32'd2);
        redirect(32'h100);
        run(12);
        chk("drop_first_pc", pr_pc, 32'h100);

        // Redirect coinciding with a response and a pop
        lat = 1;
        run(10);
        redirect(32'h300);
        run(6);
        chk("redir_with_rsp", 32'(rsp_in_redir), 32'd1);
        chk("redir_with_pop", 32'(pop_in_redir), 32'd1);
        chk("redir_rsp_pc", pr_pc, 32'h300);

        // Address wrap
        redirect(32'hFFFF_FFF8);
        run(8);
        chk("wrap_first_pc", pr_pc, 32'hFFFF_FFF8);
        chk("wrap_addr", wrap_next, 32'h0000_0000);

        // Misaligned redirect target
        redirect(32'h102);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("fault_set", 32'(bus.fetch_fault), 32'd1);
        a0 = n_acc;
        run(5);
        chk("fault_no_req", 32'(n_acc - a0), 32'd0);
        redirect(32'h200);
        run(6);
        chk("fault_cleared", 32'(bus.fetch_fault), 32'd0);
        chk("fault_resume_pc", pr_pc, 32'h200);
`else
        a0 = n_acc;
        run(6);
        chk("align_no_fault", 32'(bus.fetch_fault), 32'd0);
        chk("align_forced_pc", pr_pc, 32'h100);
        chk("align_fetching", (n_acc > a0) ? 32'd1 : 32'd0, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
